// File: rtl/pe_tile_pkg.sv
// Shared types and helpers for the PE tile engine.
//   state_e : engine FSM states (IDLE, ACCUM, DRAIN)
//   row_w   : out_row width helper, clog2(rows) with a minimum of 1
//   sext    : sign-extends the low from_w bits of a value to EXT_MAX_W bits
package pe_tile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned EXT_MAX_W = 64;

    function automatic int unsigned row_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Shift the sign bit to the top, then arithmetic-shift back down.
    function automatic logic [EXT_MAX_W-1:0] sext(input logic [EXT_MAX_W-1:0] val,
                                                  input int unsigned          from_w);
        int unsigned sh;
        sh = EXT_MAX_W - from_w;
        return EXT_MAX_W'($signed(val << sh) >>> sh);
    endfunction

endpackage

// File: rtl/pe_tile_engine_mac_cell.sv
// pe_mac_cell: one processing element of the tile.
//   clk, rst (async active-low) : clock / reset
//   clr                         : synchronous accumulator clear (wins over en)
//   en                          : accumulate a*b this cycle
//   a, b                        : signed operands
//   acc                         : signed accumulator, wraps modulo 2^ACC_WIDTH
module pe_mac_cell
    import pe_tile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] ext;

    // Full-width signed product, sign-extended into the accumulator width.
    always_comb begin
        prod = PROD_W'(a) * PROD_W'(b);
        ext  = ACC_WIDTH'(sext(EXT_MAX_W'(prod), PROD_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ext;
        end
    end

endmodule

// File: rtl/pe_tile_engine.sv
// pe_tile_engine: self-sequencing output-stationary ROWS x COLS matmul tile.
//   clk, rst (async active-low)
//   start, cfg_k          : job start (honoured in IDLE) and beat count
//   busy, done            : not-idle flag, one-cycle completion pulse
//   in_valid, in_ready    : beat handshake; act_in lane r = A[r][k], wt_in lane c = B[k][c]
//   out_valid, out_ready  : result-row handshake
//   out_data, out_row     : C[out_row][c] on lane c, and the row index
// Build option: define PE_TILE_RELU_EN to clamp negative output lanes to zero.
module pe_tile_engine
    import pe_tile_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K_WIDTH-1:0]            cfg_k,
    output logic                          busy,
    output logic                          done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]    act_in,
    input  logic [COLS*DATA_WIDTH-1:0]    wt_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*ACC_WIDTH-1:0]     out_data,
    output logic [row_w(ROWS)-1:0]        out_row
);

    localparam int unsigned       ROW_W    = row_w(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

    state_e               state, state_nx;
    logic [K_WIDTH-1:0]   k_cnt, k_cnt_nx;
    logic [ROW_W-1:0]     row_nx;
    logic                 busy_nx, done_nx, in_ready_nx, out_valid_nx;
    logic                 clr_c, beat_c, row_hs_c;

    logic signed [ACC_WIDTH-1:0] acc [ROWS][COLS];

    // Next-state, counters and registered flag values.
    always_comb begin
        state_nx = state;
        k_cnt_nx = k_cnt;
        row_nx   = out_row;
        done_nx  = 1'b0;
        clr_c    = 1'b0;
        beat_c   = in_valid & in_ready;
        row_hs_c = out_valid & out_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    clr_c    = 1'b1;
                    k_cnt_nx = cfg_k;
                    row_nx   = '0;
                    state_nx = (cfg_k == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_c) begin
                    k_cnt_nx = k_cnt - K_WIDTH'(1);
                    if (k_cnt == K_WIDTH'(1)) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (row_hs_c) begin
                    if (out_row == LAST_ROW) begin
                        row_nx   = '0;
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        row_nx = out_row + ROW_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx      = (state_nx != IDLE);
        in_ready_nx  = (state_nx == ACCUM);
        out_valid_nx = (state_nx == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k_cnt     <= '0;
            out_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            k_cnt     <= k_cnt_nx;
            out_row   <= row_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
        end
    end

    // PE grid: every PE sees its row's activation and its column's weight.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_mac_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk (clk),
                .rst (rst),
                .clr (clr_c),
                .en  (beat_c),
                .a   (act_in[r*DATA_WIDTH +: DATA_WIDTH]),
                .b   (wt_in[c*DATA_WIDTH +: DATA_WIDTH]),
                .acc (acc[r][c])
            );
        end
    end

    // Row select from the frozen accumulators; zero whenever no row is presented.
    always_comb begin
        logic signed [ACC_WIDTH-1:0] lane;
        out_data = '0;
        for (int c = 0; c < COLS; c++) begin
            lane = acc[out_row][c];
`ifdef PE_TILE_RELU_EN
            if (lane[ACC_WIDTH-1]) begin
                lane = '0;
            end
`endif
            if (out_valid) begin
                out_data[c*ACC_WIDTH +: ACC_WIDTH] = lane;
            end
        end
    end

endmodule

// File: tb/tb_pe_tile_engine.sv
// Bench for pe_tile_engine: random and directed jobs against a plain-arithmetic
// matrix model; a negedge monitor checks every presented row and the done pulse.
// Honours PE_TILE_RELU_EN in its expectations.
module tb_pe_tile_engine;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int KW   = 8;

    logic                 clk = 1'b0;
    logic                 rst, start, in_valid, out_ready;
    logic [KW-1:0]        cfg_k;
    logic [ROWS*DW-1:0]   act_in;
    logic [COLS*DW-1:0]   wt_in;
    logic                 busy, done, in_ready, out_valid;
    logic [COLS*AW-1:0]   out_data;
    logic [1:0]           out_row;

    always #5 clk = ~clk;

    pe_tile_engine #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wt_in(wt_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
    );

    typedef struct {
        logic [COLS*AW-1:0] data;
        int                 row;
        bit                 last;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   done_exp = 1'b0;

    // Wrap to the accumulator width, then clamp when the ReLU build is selected.
    function automatic logic [AW-1:0] shape(input longint v);
        logic [AW-1:0] w;
        w = AW'(v);
`ifdef PE_TILE_RELU_EN
        if (w[AW-1]) w = '0;
`endif
        return w;
    endfunction

    task automatic check_eq(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row/done monitor: compares each presented row with the model queue.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (done !== done_exp) begin
                errors++;
                $display("FAIL done_pulse: got %b expected %b", done, done_exp);
            end
            done_exp = 1'b0;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_row: out_row=%0d data=%h with no row expected",
                             out_row, out_data);
                end else begin
                    if (int'(out_row) != q[0].row || out_data !== q[0].data) begin
                        errors++;
                        $display("FAIL row_data: got row %0d data %h expected row %0d data %h",
                                 out_row, out_data, q[0].row, q[0].data);
                    end
                    if (out_ready) begin
                        done_exp = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // One job: start, k beats (with optional bubbles), then drain under a ready policy.
    task automatic run_job(input int k, input int dmode, input int aval, input int wval,
                           input int gap, input int pol, input bit lit_en, input int lit);
        longint macc [ROWS][COLS];
        int     a [ROWS];
        int     b [COLS];
        int     guard;
        int     stall;
        bit     pulsed;
        exp_t   e;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                macc[r][c] = 0;

        guard = 0;
        while (busy && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) check_eq("idle_timeout", 1, 0);

        start = 1'b1;
        cfg_k = KW'(k);
        tick();
        start = 1'b0;
        cfg_k = KW'($urandom);
        check_eq("busy_after_start", longint'(busy), 1);
        check_eq("in_ready_after_start", longint'(in_ready), (k != 0) ? 1 : 0);

        for (int i = 0; i < k; i++) begin
            int nb;
            nb = (gap == 1 && i > 0) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
            for (int n = 0; n < nb; n++) begin
                in_valid = 1'b0;
                act_in   = ROWS*DW'($urandom);
                wt_in    = COLS*DW'($urandom);
                tick();
            end
            for (int r = 0; r < ROWS; r++) begin
                a[r] = (dmode == 0) ? aval : $urandom_range(0, 255) - 128;
                act_in[r*DW +: DW] = DW'(a[r]);
            end
            for (int c = 0; c < COLS; c++) begin
                b[c] = (dmode == 0) ? wval : $urandom_range(0, 255) - 128;
                wt_in[c*DW +: DW] = DW'(b[c]);
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    macc[r][c] += longint'(a[r]) * longint'(b[c]);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;

        for (int r = 0; r < ROWS; r++) begin
            e.data = '0;
            for (int c = 0; c < COLS; c++) e.data[c*AW +: AW] = shape(macc[r][c]);
            e.row  = r;
            e.last = (r == ROWS - 1);
            q.push_back(e);
        end

        check_eq("in_ready_after_last_beat", longint'(in_ready), 0);
        check_eq("out_valid_first_drain", longint'(out_valid), 1);
        if (lit_en) begin
            check_eq("model_lit_lane0", longint'(q[0].data[0 +: AW]), longint'(shape(lit)));
            check_eq("dut_lit_lane0", longint'(out_data[0 +: AW]), longint'(shape(lit)));
            check_eq("dut_lit_lane_last", longint'(out_data[(COLS-1)*AW +: AW]),
                     longint'(shape(lit)));
        end

        guard  = 0;
        stall  = 0;
        pulsed = 1'b0;
        while (q.size() > 0 && guard < 300) begin
            case (pol)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && out_row == 2'd1 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (pol == 2 && stall == 3 && !pulsed) begin
                start  = 1'b1;
                cfg_k  = KW'(5);
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            guard++;
        end
        start = 1'b0;
        if (guard >= 300) begin
            check_eq("drain_timeout", 1, 0);
            q.delete();
        end
        if (pol == 2) check_eq("stall_cycles", stall, 5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_k = '0; act_in = '0; wt_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        check_eq("rst_in_ready", longint'(in_ready), 0);
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_out_row", longint'(out_row), 0);
        check_eq("rst_out_data", longint'(out_data != '0), 0);
        rst = 1'b1;
        tick();

        run_job(1, 0, 2, 3, 0, 0, 1, 6);
        run_job(3, 0, -128, -128, 0, 0, 1, 49152);
        run_job(3, 0, -128, 127, 0, 0, 1, -48768);
        run_job(4, 1, 0, 0, 1, 0, 0, 0);
        run_job(4, 1, 0, 0, 0, 2, 0, 0);
        run_job(0, 0, 5, 5, 0, 0, 1, 0);

        // Reset in the middle of a job.
        start = 1'b1; cfg_k = KW'(4);
        tick();
        start = 1'b0;
        act_in = {ROWS{8'd1}}; wt_in = {COLS{8'd1}}; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", longint'(busy), 0);
        check_eq("midrst_out_valid", longint'(out_valid), 0);
        check_eq("midrst_in_ready", longint'(in_ready), 0);
        q.delete();
        done_exp = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_job(1, 0, 1, -5, 0, 0, 1, -5);

        repeat (6) run_job($urandom_range(1, 12), 1, 0, 0, 2, 1, 0, 0);
        run_job(255, 0, -128, -128, 0, 1, 1, 4177920);

        repeat (3) tick();
        check_eq("final_idle", longint'(busy), 0);
        check_eq("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
